micro_sequencer: RTL and testbench
==================================

# micro_sequencer

Micro-program sequencer for the processor control unit. Owns the micro-PC that addresses the 32-entry, 36-bit combinational control store. Picks each next micro-address from the control word's next-address field, the instruction opcode dispatch, the zero flag, and memory wait handshakes. Gates the control word to the datapath and reports run, halt and illegal-opcode status to the core wrapper.

## Interface
Parameters:
- AW, 5, micro-address width.
- CW, 36, control-word width.
- CNT_W, 16, width of the dispatched-instruction counter.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle pulse; begins execution at micro-address 0 from IDLE/DONE.
- cs_i  in  CW  control word read from the store at addr_o (same cycle, combinational).
- opcode_i  in  5  instruction opcode; must be valid in every cycle where addr_o==1.
- z_i  in  1  datapath zero flag, sampled at dispatch.
- mem_ready_i  in  1  memory completion for the current access.
- addr_o  out  AW  registered micro-PC, drives the store address.
- cs_valid_o  out  1  control word on cs_i may be applied by the datapath this cycle.
- mem_wait_o  out  1  sequencer stalled on memory.
- done_o  out  1  program halted (normal or illegal).
- illegal_o  out  1  sticky: an illegal opcode was dispatched.
- instr_cnt_o  out  CNT_W  number of successful dispatches since start, saturating.

## Operation
- The next-address field is nxt = cs_i[4:0]. The value 31 means HALT. Any other value is the literal next micro-address.
- States:
  - IDLE: after reset.
  - RUN
  - WAIT: memory stall.
  - DONE
- IDLE/DONE behaviour:
  - start_i moves to RUN with upc<=0.
  - On that edge, illegal_o and instr_cnt_o clear.
  - start_i is ignored in RUN/WAIT.
- In RUN, cs_valid_o=1. The next micro-PC is chosen in priority order:
  1. upc ∈ {19,21,22} (memory micro-ops) and mem_ready_i=0: go to WAIT, upc held.
  2. upc==1 (dispatch): apply the opcode map below.
  3. nxt==31: go to DONE, upc held.
  4. Otherwise upc<=nxt.
- Opcode map (legal opcode value = start address):
  - 2, 3, 4, 5, 12–19, 21, 24, 25, 26 go to their own address.
  - 9 goes to 9 if z_i==0, else 11.
  - All other opcodes (0,1,6,7,8,10,11,20,22,23,27–31) are illegal. Set illegal_o=1 and go to DONE; instr_cnt_o does not increment.
- Every legal dispatch increments instr_cnt_o, saturating at all-ones.
- WAIT behaviour:
  - cs_valid_o=0 and mem_wait_o=1; upc held.
  - On mem_ready_i=1, return to RUN with upc<=nxt in the same edge, using the held word's field.
  - The memory micro-op's side effects are therefore applied exactly once: in the first RUN cycle only.
- DONE: done_o=1, cs_valid_o=0, addr_o held.
- While not in RUN, the datapath must ignore cs_i.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, addr_o=0, cs_valid_o=0, mem_wait_o=0, done_o=0, illegal_o=0, instr_cnt_o=0.
- Reset asserted mid-instruction or mid-WAIT aborts immediately to the above values. No pending memory state is retained.
- start_i is sampled at edge T. RUN begins at T, with addr_o=0 and cs_valid_o=1 in cycle T+1.
- One micro-instruction per cycle in RUN. An instruction taking k micro-words with no stalls occupies k+2 cycles including FETCH1/FETCH2.
- Memory stall: ready in the first cycle gives zero penalty. Ready after n WAIT cycles adds n cycles.
- mem_ready_i is ignored outside upc ∈ {19,21,22}.
- start_i coincident with reset deassertion is ignored (reset wins).
- Saturated instr_cnt_o stays at 2^CNT_W−1.
- All outputs are registered, except cs_valid_o and mem_wait_o, which decode from the state register only (no input-to-output paths).

## Test plan
- Reset/idle: hold rst_n=0, then release with no start.
  - Required: addr_o=0, cs_valid_o=0, done_o=0 indefinitely.
- ADD program: start, opcode 16 at dispatch, then opcode 26.
  - Required: addr_o sequence 0,1,16,0,1,26 with cs_valid_o=1 throughout, then done_o=1, instr_cnt_o=2.
- JMPNZ: opcode 9 with z_i=0, and separately with z_i=1.
  - Required: the 0,1,9,10,0 path, and the 0,1,11,0 path.
- LOAD with stall: opcode 19, mem_ready_i low for 3 cycles.
  - Required: addr_o=19 for 4 cycles; cs_valid_o=1 in the first, 0 in the 3 WAIT cycles with mem_wait_o=1; then addr_o=20, then 0.
- Illegal opcode 7.
  - Required: illegal_o=1 and done_o=1 after the dispatch edge, instr_cnt_o unchanged.
  - A following start_i clears illegal_o and restarts at 0.
- Reset mid-WAIT during STORE (addr_o=22).
  - Required: all outputs immediately at their reset values, state IDLE.

Source files
------------

// File: rtl/micro_sequencer.sv
// Micro-program sequencer: owns the micro-PC into a 32-entry control store and
// selects the next micro-address from next-field, opcode dispatch and memory waits.
module micro_sequencer #(
    parameter int AW    = 5,
    parameter int CW    = 36,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CW-1:0]    cs_i,
    input  logic [4:0]       opcode_i,
    input  logic             z_i,
    input  logic             mem_ready_i,
    output logic [AW-1:0]    addr_o,
    output logic             cs_valid_o,
    output logic             mem_wait_o,
    output logic             done_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

    state_t           state, next_state;
    logic [AW-1:0]    next_upc;
    logic             next_illegal;
    logic [CNT_W-1:0] next_cnt;
    logic [4:0]       nxt;
    logic             halt;
    logic             mem_op;
    logic             legal;
    logic [AW-1:0]    target;
    logic             unused_cs;

    assign nxt       = cs_i[4:0];
    assign halt      = (nxt == 5'd31);
    assign unused_cs = ^cs_i[CW-1:5];
    assign mem_op    = (addr_o == AW'(19)) || (addr_o == AW'(21)) || (addr_o == AW'(22));

    assign cs_valid_o = (state == RUN);
    assign mem_wait_o = (state == WAIT);

    // Opcode value doubles as routine start address; opcode 9 branches on z.
    always_comb begin
        legal  = 1'b1;
        target = AW'(opcode_i);
        case (opcode_i)
            5'd2, 5'd3, 5'd4, 5'd5, 5'd12, 5'd13, 5'd14, 5'd15,
            5'd16, 5'd17, 5'd18, 5'd19, 5'd21, 5'd24, 5'd25, 5'd26: ;
            5'd9:    target = z_i ? AW'(11) : AW'(9);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        next_state   = state;
        next_upc     = addr_o;
        next_illegal = illegal_o;
        next_cnt     = instr_cnt_o;
        case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    next_state   = RUN;
                    next_upc     = '0;
                    next_illegal = 1'b0;
                    next_cnt     = '0;
                end
            end
            RUN: begin
                if (mem_op && !mem_ready_i) begin
                    next_state = WAIT;
                end else if (addr_o == AW'(1)) begin
                    if (legal) begin
                        next_upc = target;
                        if (instr_cnt_o != '1)
                            next_cnt = instr_cnt_o + 1'b1;
                    end else begin
                        next_illegal = 1'b1;
                        next_state   = DONE;
                    end
                end else if (halt) begin
                    next_state = DONE;
                end else begin
                    next_upc = AW'(nxt);
                end
            end
            WAIT: begin
                // Leave via the held word's next field so the memory op is not replayed.
                if (mem_ready_i) begin
                    if (halt) begin
                        next_state = DONE;
                    end else begin
                        next_state = RUN;
                        next_upc   = AW'(nxt);
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_o      <= '0;
            done_o      <= 1'b0;
            illegal_o   <= 1'b0;
            instr_cnt_o <= '0;
        end else begin
            state       <= next_state;
            addr_o      <= next_upc;
            done_o      <= (next_state == DONE);
            illegal_o   <= next_illegal;
            instr_cnt_o <= next_cnt;
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench: expected micro-address stream comes from per-opcode routine
// lists; a monitor pops and compares whenever the sequencer presents a word or stalls.
module tb_micro_sequencer;

    localparam int AW    = 5;
    localparam int CW    = 36;
    localparam int CNT_W = 3;
    localparam int SAT   = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic [CW-1:0]    cs_i;
    logic [4:0]       opcode_i = '0;
    logic             z_i = 1'b0;
    logic             mem_ready_i = 1'b0;
    logic [AW-1:0]    addr_o;
    logic             cs_valid_o;
    logic             mem_wait_o;
    logic             done_o;
    logic             illegal_o;
    logic [CNT_W-1:0] instr_cnt_o;

    micro_sequencer #(.AW(AW), .CW(CW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .cs_i(cs_i),
        .opcode_i(opcode_i), .z_i(z_i), .mem_ready_i(mem_ready_i),
        .addr_o(addr_o), .cs_valid_o(cs_valid_o), .mem_wait_o(mem_wait_o),
        .done_o(done_o), .illegal_o(illegal_o), .instr_cnt_o(instr_cnt_o)
    );

    always #5 clk = ~clk;

    logic [4:0]  nxt_tab [32];
    logic [30:0] hi_tab  [32];
    assign cs_i = {hi_tab[addr_o], nxt_tab[addr_o]};

    typedef struct { int addr; bit wait_f; } rec_t;
    typedef struct { bit ill; int cnt; } end_t;

    rec_t exp_q[$];
    end_t end_q[$];
    int   op_q[$];
    bit   z_q[$];
    int   dly_q[$];
    int   rt[32][$];
    int   rt9z[$];
    int   prog_ops[$];
    bit   prog_zs[$];

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   done_seen = 1'b1;
    int   mem_left = 0;
    int   force_dly = -1;
    rec_t mr;
    end_t me;

    int legal_ops[16]   = '{2, 3, 4, 5, 9, 12, 13, 14, 15, 16, 17, 18, 19, 21, 24, 25};
    int illegal_ops[15] = '{0, 1, 6, 7, 8, 10, 11, 20, 22, 23, 27, 28, 29, 30, 31};

    function automatic bit is_mem(input int a);
        return (a == 19) || (a == 21) || (a == 22);
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"}, int'(addr_o), 0);
        chk({tag, "_valid"}, int'(cs_valid_o), 0);
        chk({tag, "_wait"}, int'(mem_wait_o), 0);
        chk({tag, "_done"}, int'(done_o), 0);
        chk({tag, "_illegal"}, int'(illegal_o), 0);
        chk({tag, "_cnt"}, int'(instr_cnt_o), 0);
    endtask

    // Expected cycle records for one instruction: fetch words 0,1 then its routine.
    task automatic push_instr(input int op, input bit z, output bit legal);
        int path[$];
        int d;
        exp_q.push_back('{addr: 0, wait_f: 1'b0});
        exp_q.push_back('{addr: 1, wait_f: 1'b0});
        op_q.push_back(op);
        z_q.push_back(z);
        if (op == 9 && z) path = rt9z;
        else path = rt[op];
        legal = (path.size() > 0);
        foreach (path[i]) begin
            exp_q.push_back('{addr: path[i], wait_f: 1'b0});
            if (is_mem(path[i])) begin
                d = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
                dly_q.push_back(d);
                for (int k = 0; k < d; k++) exp_q.push_back('{addr: path[i], wait_f: 1'b1});
            end
        end
    endtask

    task automatic clear_queues();
        exp_q.delete(); end_q.delete(); op_q.delete(); z_q.delete(); dly_q.delete();
        mem_left = 0;
    endtask

    task automatic run_prog();
        bit legal;
        bit ill = 1'b0;
        bit fin = 1'b0;
        int n = 0;
        foreach (prog_ops[i]) begin
            push_instr(prog_ops[i], prog_zs[i], legal);
            if (!legal) begin
                ill = 1'b1;
                break;
            end
            n++;
        end
        end_q.push_back('{ill: ill, cnt: (n > SAT) ? SAT : n});
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (done_o && done_seen && exp_q.size() == 0 && end_q.size() == 0) begin
                fin = 1'b1;
                break;
            end
            // start_i must be ignored while running
            start_i = done_o ? 1'b0 : 1'($urandom_range(0, 1));
        end
        start_i = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL prog_timeout done=%0d pending=%0d expected_pending=0", done_o, exp_q.size());
            clear_queues();
            done_seen = 1'b1;
        end
    endtask

    // Environment: answers dispatch with the queued opcode and memory ops with the planned delay.
    always @(negedge clk) begin
        mem_ready_i = 1'($urandom_range(0, 1));
        opcode_i    = 5'($urandom);
        z_i         = 1'($urandom_range(0, 1));
        if (cs_valid_o && addr_o == 5'd1 && op_q.size() > 0) begin
            opcode_i = 5'(op_q.pop_front());
            z_i      = z_q.pop_front();
        end
        if (is_mem(int'(addr_o)) && (cs_valid_o || mem_wait_o)) begin
            if (cs_valid_o && dly_q.size() > 0) mem_left = dly_q.pop_front();
            mem_ready_i = (mem_left == 0);
            mem_left--;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (cs_valid_o || mem_wait_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL seq_extra got addr=%0d wait=%0d expected=no_activity", addr_o, mem_wait_o);
                end else begin
                    mr = exp_q.pop_front();
                    if (int'(addr_o) != mr.addr || mem_wait_o != mr.wait_f || (cs_valid_o && mem_wait_o)) begin
                        errors++;
                        $display("FAIL seq got addr=%0d valid=%0d wait=%0d expected addr=%0d wait=%0d",
                                 addr_o, cs_valid_o, mem_wait_o, mr.addr, mr.wait_f);
                    end
                end
            end
            if (done_o && !done_seen) begin
                done_seen = 1'b1;
                checks++;
                if (end_q.size() == 0) begin
                    errors++;
                    $display("FAIL end_extra got done=1 expected=running");
                end else begin
                    me = end_q.pop_front();
                    if (illegal_o != me.ill || int'(instr_cnt_o) != me.cnt || exp_q.size() != 0) begin
                        errors++;
                        $display("FAIL end got illegal=%0d cnt=%0d pending=%0d expected illegal=%0d cnt=%0d pending=0",
                                 illegal_o, instr_cnt_o, exp_q.size(), me.ill, me.cnt);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int found;
        rt[2] = {2};   rt[3] = {3};   rt[4] = {4};   rt[5] = {5, 6, 7};
        rt[9] = {9, 10};              rt9z = {11};
        rt[12] = {12}; rt[13] = {13}; rt[14] = {14}; rt[15] = {15};
        rt[16] = {16}; rt[17] = {17}; rt[18] = {18}; rt[19] = {19, 20};
        rt[21] = {21}; rt[24] = {24, 22, 23};        rt[25] = {25}; rt[26] = {26};
        for (int a = 0; a < 32; a++) begin
            nxt_tab[a] = 5'd0;
            hi_tab[a]  = 31'($urandom);
        end
        for (int op = 0; op < 32; op++)
            foreach (rt[op][i])
                nxt_tab[rt[op][i]] = (i + 1 < rt[op].size()) ? 5'(rt[op][i + 1]) : ((op == 26) ? 5'd31 : 5'd0);
        nxt_tab[11] = 5'd0;
        nxt_tab[0]  = 5'd1;
        nxt_tab[1]  = 5'd31;
        nxt_tab[31] = 5'd31;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_held");
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_addr", int'(addr_o), 0);
            chk("idle_valid", int'(cs_valid_o), 0);
            chk("idle_done", int'(done_o), 0);
        end
        mon_en = 1'b1;

        prog_ops = {16, 26}; prog_zs = {1'b0, 1'b0}; run_prog();
        prog_ops = {9, 26};  prog_zs = {1'b0, 1'b0}; run_prog();
        prog_ops = {9, 26};  prog_zs = {1'b1, 1'b0}; run_prog();
        force_dly = 3;
        prog_ops = {19, 26}; prog_zs = {1'b0, 1'b0}; run_prog();
        force_dly = 0;
        prog_ops = {21, 24, 26}; prog_zs = {1'b0, 1'b0, 1'b0}; run_prog();
        force_dly = -1;
        prog_ops = {16, 7};  prog_zs = {1'b0, 1'b0}; run_prog();
        prog_ops = {26};     prog_zs = {1'b0}; run_prog();
        prog_ops = {2, 3, 4, 5, 12, 13, 14, 15, 16, 26};
        prog_zs  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_prog();

        for (int p = 0; p < 30; p++) begin
            prog_ops.delete();
            prog_zs.delete();
            n = $urandom_range(0, 9);
            for (int i = 0; i < n; i++) begin
                prog_ops.push_back(legal_ops[$urandom_range(0, 15)]);
                prog_zs.push_back(1'($urandom_range(0, 1)));
            end
            prog_ops.push_back(($urandom_range(0, 2) != 0) ? 26 : illegal_ops[$urandom_range(0, 14)]);
            prog_zs.push_back(1'b0);
            run_prog();
        end

        // Abort a STORE stall at address 22 with an asynchronous reset.
        force_dly = 100;
        prog_ops = {24, 26}; prog_zs = {1'b0, 1'b0};
        push_instr(24, 1'b0, found[0]);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        found = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (mem_wait_o && addr_o == 5'd22) begin
                found = 1;
                break;
            end
        end
        chk("reach_store_wait", found, 1);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset_mid_wait");
        clear_queues();
        force_dly = -1;
        done_seen = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_valid", int'(cs_valid_o), 0);
            chk("post_reset_wait", int'(mem_wait_o), 0);
            chk("post_reset_done", int'(done_o), 0);
        end
        mon_en = 1'b1;
        prog_ops = {16, 26}; prog_zs = {1'b0, 1'b0}; run_prog();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
